calc_entry_sequencer: RTL and testbench
=======================================

// Module: calc_entry_sequencer
// PURPOSE
//  Keypad-driven controller for the calculator datapath. It accepts key events and
//  selects operand A or B, building each from up to MAX_DIGITS decimal digits. It
//  latches the operator, then on EXECUTE runs a start/done handshake with the ALU and
//  holds the result for display. It sits between the keypad decoder and the ALU.
// PARAMETERS
//  W           32   operand/result width (bits)
//  MAX_DIGITS  2    max decimal digits per operand; further digits are ignored
//  TIMEOUT     255  max cycles in WAIT for alu_done before abort
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  key_valid    in   1   one-cycle pulse: key_code is valid this cycle
//  key_code     in   4   0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 EXECUTE, 14 SEL_A, 15 SEL_B
//  alu_done     in   1   one-cycle pulse from ALU: alu_result valid
//  alu_result   in   W   ALU result, sampled when alu_done=1
//  operand_a    out  W   operand A to ALU
//  operand_b    out  W   operand B to ALU
//  op_code      out  2   00 add, 01 sub, 10 mul
//  alu_start    out  1   one-cycle start pulse to ALU
//  result_out   out  W   captured ALU result
//  result_valid out  1   result_out valid (level)
//  led_a        out  1   operand A selected for entry
//  led_b        out  1   operand B selected for entry
//  busy         out  1   1 in ISSUE/WAIT
//  err          out  1   sticky error flag
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; internal sel=A, digit_cnt=0, op_set=0, wait_cnt=0.
//  States: IDLE, ENTRY, ISSUE, WAIT, DONE. Keys are acted on only in cycles with key_valid=1.
//  Key effects occur on the first clk edge after key_valid (1-cycle latency).
//  SEL_A (14), any state except ISSUE/WAIT: sel=A, operand_a=0, digit_cnt=0, led_a=1, led_b=0,
//   result_valid=0, err=0, ->ENTRY. SEL_B (15): the same for B (led_a=0, led_b=1).
//  Digit d in ENTRY: if digit_cnt<MAX_DIGITS, selected operand <= operand*10+d (truncate
//   to W), digit_cnt++; otherwise ignored. Digits in IDLE/DONE are ignored.
//  ADD/SUB/MUL in IDLE/ENTRY/DONE: op_code=key_code-10, op_set=1; state unchanged.
//  EXECUTE in IDLE/ENTRY/DONE: if op_set=1 ->ISSUE, clear result_valid;
//   else err=1 and state unchanged.
//  ISSUE: alu_start=1 for exactly this one cycle; wait_cnt=0; ->WAIT.
//   operand_a/b and op_code are frozen from ISSUE until WAIT is left.
//  WAIT: if alu_done: result_out=alu_result, result_valid=1, ->DONE (done-to-valid is 1 cycle).
//   Else if wait_cnt==TIMEOUT-1: err=1, ->IDLE. Else wait_cnt++.
//   alu_done and timeout in the same cycle: done wins.
//  DONE: result_valid held; the next SEL_A/SEL_B clears it; EXECUTE reissues with the held operands.
//  All keys arriving in ISSUE/WAIT are dropped (no queueing, no err).
//  alu_done outside WAIT: ignored.
//  led_a/led_b keep their values through ISSUE/WAIT/DONE; err clears only on SEL_A/SEL_B or rst.
//  rst mid-operation (any state, incl. WAIT): full reset next edge; a later alu_done is ignored.
// TESTING
//  rst; SEL_A,4,2,SEL_B,7,ADD,EXEC -> operand_a=42, operand_b=7, op_code=00, one alu_start pulse,
//   busy=1.
//  alu_done with alu_result=49 two cycles after start -> result_out=49, result_valid=1 next cycle,
//   state DONE.
//  SEL_A,1,2,3 (MAX_DIGITS=2) -> operand_a=12; SEL_A again -> operand_a=0, digit_cnt reset.
//  rst; SEL_A,5,EXEC with no operator -> err=1, no alu_start; SEL_B -> err=0.
//  Valid operation to EXEC, no alu_done for TIMEOUT cycles -> err=1, IDLE, result_valid=0;
//   digit keys during WAIT leave operands unchanged.
//  rst asserted during WAIT, alu_done one cycle later -> all outputs 0, result_valid stays 0.

Source files
------------

// File: rtl/calc_entry_sequencer.sv
// ---------------------------------------------------------------------------
// calc_entry_sequencer
//
// Purpose:
//   Keypad-driven controller for the calculator datapath. Key events select
//   operand A or B and build it from up to MAX_DIGITS decimal digits. The
//   operator key latches the ALU opcode. EXECUTE issues a start/done
//   handshake with the ALU, and the returned result is held for display.
//   Keys arriving while an ALU operation is in flight are dropped.
//
// Parameters:
//   W           operand/result width in bits
//   MAX_DIGITS  max decimal digits per operand; extra digits are ignored
//   TIMEOUT     max cycles spent waiting for alu_done before aborting
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   key_valid    in   one-cycle pulse, key_code valid this cycle
//   key_code     in   0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 EXECUTE,
//                     14 SEL_A, 15 SEL_B
//   alu_done     in   one-cycle pulse from the ALU, alu_result valid
//   alu_result   in   ALU result, sampled when alu_done is high
//   operand_a    out  operand A to the ALU
//   operand_b    out  operand B to the ALU
//   op_code      out  00 add, 01 sub, 10 mul
//   alu_start    out  one-cycle start pulse to the ALU
//   result_out   out  captured ALU result
//   result_valid out  result_out holds a valid result (level)
//   led_a        out  operand A selected for entry
//   led_b        out  operand B selected for entry
//   busy         out  high while an ALU operation is being issued/awaited
//   err          out  sticky error flag, cleared by SEL_A/SEL_B or reset
// ---------------------------------------------------------------------------
module calc_entry_sequencer #(
    parameter int W          = 32,
    parameter int MAX_DIGITS = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    output logic [W-1:0] operand_a,
    output logic [W-1:0] operand_b,
    output logic [1:0]   op_code,
    output logic         alu_start,
    output logic [W-1:0] result_out,
    output logic         result_valid,
    output logic         led_a,
    output logic         led_b,
    output logic         busy,
    output logic         err
);

    localparam int DCW = $clog2(MAX_DIGITS + 1);
    localparam int WCW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] KEY_MUL   = 4'd12;
    localparam logic [3:0] KEY_EXEC  = 4'd13;
    localparam logic [3:0] KEY_SEL_A = 4'd14;
    localparam logic [3:0] KEY_SEL_B = 4'd15;

    localparam logic [W-1:0]   TEN        = W'(10);
    localparam logic [DCW-1:0] DIGIT_LIM  = DCW'(MAX_DIGITS);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t         state, next_state;

    // sel_b low means operand A receives digits
    logic           sel_b, next_sel_b;
    logic [DCW-1:0] digit_cnt, next_digit_cnt;
    logic           op_set, next_op_set;
    logic [WCW-1:0] wait_cnt, next_wait_cnt;

    logic [W-1:0]   next_operand_a, next_operand_b, next_result_out;
    logic [1:0]     next_op_code;
    logic           next_result_valid, next_led_a, next_led_b, next_err;

    logic [W-1:0]   digit_ext;

    assign digit_ext = W'(key_code);

    // The start pulse and busy flag are pure decodes of the state, so the
    // pulse is exactly as long as the single ISSUE cycle.
    assign alu_start = (state == S_ISSUE);
    assign busy      = (state == S_ISSUE) || (state == S_WAIT);

    // State and datapath registers. Everything returns to zero on reset,
    // which also makes operand A the selected operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            sel_b        <= 1'b0;
            digit_cnt    <= '0;
            op_set       <= 1'b0;
            wait_cnt     <= '0;
            operand_a    <= '0;
            operand_b    <= '0;
            op_code      <= 2'b00;
            result_out   <= '0;
            result_valid <= 1'b0;
            led_a        <= 1'b0;
            led_b        <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= next_state;
            sel_b        <= next_sel_b;
            digit_cnt    <= next_digit_cnt;
            op_set       <= next_op_set;
            wait_cnt     <= next_wait_cnt;
            operand_a    <= next_operand_a;
            operand_b    <= next_operand_b;
            op_code      <= next_op_code;
            result_out   <= next_result_out;
            result_valid <= next_result_valid;
            led_a        <= next_led_a;
            led_b        <= next_led_b;
            err          <= next_err;
        end
    end

    // Next-state and register-update logic. Every register holds by default,
    // which is what freezes the operands and opcode during ISSUE/WAIT.
    always_comb begin
        next_state        = state;
        next_sel_b        = sel_b;
        next_digit_cnt    = digit_cnt;
        next_op_set       = op_set;
        next_wait_cnt     = wait_cnt;
        next_operand_a    = operand_a;
        next_operand_b    = operand_b;
        next_op_code      = op_code;
        next_result_out   = result_out;
        next_result_valid = result_valid;
        next_led_a        = led_a;
        next_led_b        = led_b;
        next_err          = err;

        case (state)
            S_IDLE, S_ENTRY, S_DONE: begin
                if (key_valid) begin
                    if (key_code == KEY_SEL_A || key_code == KEY_SEL_B) begin
                        next_sel_b        = (key_code == KEY_SEL_B);
                        next_digit_cnt    = '0;
                        next_led_a        = (key_code == KEY_SEL_A);
                        next_led_b        = (key_code == KEY_SEL_B);
                        next_result_valid = 1'b0;
                        next_err          = 1'b0;
                        next_state        = S_ENTRY;
                        if (key_code == KEY_SEL_B) begin
                            next_operand_b = '0;
                        end else begin
                            next_operand_a = '0;
                        end
                    end else if (key_code <= 4'd9) begin
                        // Digits only build an operand while in ENTRY
                        if (state == S_ENTRY && digit_cnt < DIGIT_LIM) begin
                            next_digit_cnt = digit_cnt + 1'b1;
                            if (sel_b) begin
                                next_operand_b = operand_b * TEN + digit_ext;
                            end else begin
                                next_operand_a = operand_a * TEN + digit_ext;
                            end
                        end
                    end else if (key_code <= KEY_MUL) begin
                        // key_code - 10 for codes 10..12: adding 2 to the
                        // low two bits maps 10->0, 11->1, 12->2.
                        next_op_code = key_code[1:0] + 2'd2;
                        next_op_set  = 1'b1;
                    end else if (key_code == KEY_EXEC) begin
                        if (op_set) begin
                            next_result_valid = 1'b0;
                            next_state        = S_ISSUE;
                        end else begin
                            next_err = 1'b1;
                        end
                    end
                end
            end

            S_ISSUE: begin
                next_wait_cnt = '0;
                next_state    = S_WAIT;
            end

            S_WAIT: begin
                // A done arriving in the last allowed cycle still wins over
                // the timeout.
                if (alu_done) begin
                    next_result_out   = alu_result;
                    next_result_valid = 1'b1;
                    next_state        = S_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_err   = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_wait_cnt = wait_cnt + 1'b1;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_entry_sequencer
//
// Directed scenarios followed by a randomized key stream. Expected outputs
// come from a behavioural model: each operand is a queue of entered digits
// whose decimal value is folded on demand, and the ALU handshake timing is
// tracked by the bench itself since it plays the ALU.
// ---------------------------------------------------------------------------
module tb_calc_entry_sequencer;

    localparam int W    = 32;
    localparam int MAXD = 2;
    localparam int TO   = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         alu_done;
    logic [W-1:0] alu_result;
    logic [W-1:0] operand_a, operand_b, result_out;
    logic [1:0]   op_code;
    logic         alu_start, result_valid, led_a, led_b, busy, err;

    always #5 clk = ~clk;

    calc_entry_sequencer #(.W(W), .MAX_DIGITS(MAXD), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op_code     (op_code),
        .alu_start   (alu_start),
        .result_out  (result_out),
        .result_valid(result_valid),
        .led_a       (led_a),
        .led_b       (led_b),
        .busy        (busy),
        .err         (err)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Behavioural model state
    int           qa[$];
    int           qb[$];
    bit           m_sel_b, m_entry, m_op_set, m_rv, m_led_a, m_led_b, m_err;
    bit           m_start, m_busy;
    logic [1:0]   m_op;
    logic [W-1:0] m_res;

    function automatic logic [W-1:0] fold(input int q[$]);
        logic [W-1:0] v = '0;
        foreach (q[i]) v = v * W'(10) + W'(q[i]);
        return v;
    endfunction

    task automatic modelReset();
        qa.delete();
        qb.delete();
        m_sel_b  = 0; m_entry = 0; m_op_set = 0; m_rv = 0;
        m_led_a  = 0; m_led_b = 0; m_err = 0; m_start = 0; m_busy = 0;
        m_op     = 2'b00;
        m_res    = '0;
    endtask

    // Apply one key to the model while no operation is in flight
    task automatic modelKey(input logic [3:0] c, output bit issue);
        issue = 0;
        if (c == 4'd14 || c == 4'd15) begin
            m_sel_b = (c == 4'd15);
            if (m_sel_b) qb.delete(); else qa.delete();
            m_led_a = !m_sel_b;
            m_led_b = m_sel_b;
            m_rv    = 0;
            m_err   = 0;
            m_entry = 1;
        end else if (c <= 4'd9) begin
            if (m_entry) begin
                if (m_sel_b && qb.size() < MAXD) qb.push_back(int'(c));
                else if (!m_sel_b && qa.size() < MAXD) qa.push_back(int'(c));
            end
        end else if (c <= 4'd12) begin
            m_op     = 2'(int'(c) - 10);
            m_op_set = 1;
        end else begin
            if (m_op_set) begin
                issue   = 1;
                m_rv    = 0;
                m_entry = 0;
                m_start = 1;
                m_busy  = 1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic cmp(input string tag, input string sig,
                       input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) begin
            passed++;
        end else begin
            fails++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, sig, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp(tag, "operand_a",    operand_a,          fold(qa));
        cmp(tag, "operand_b",    operand_b,          fold(qb));
        cmp(tag, "op_code",      W'(op_code),        W'(m_op));
        cmp(tag, "alu_start",    W'(alu_start),      W'(m_start));
        cmp(tag, "result_out",   result_out,         m_res);
        cmp(tag, "result_valid", W'(result_valid),   W'(m_rv));
        cmp(tag, "led_a",        W'(led_a),          W'(m_led_a));
        cmp(tag, "led_b",        W'(led_b),          W'(m_led_b));
        cmp(tag, "busy",         W'(busy),           W'(m_busy));
        cmp(tag, "err",          W'(err),            W'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        alu_done   = 1'b0;
        alu_result = '0;
    endtask

    task automatic applyStimulus(input bit kv, input logic [3:0] kc,
                                 input bit dn, input logic [W-1:0] res);
        key_valid  = kv;
        key_code   = kc;
        alu_done   = dn;
        alu_result = res;
        tick();
    endtask

    // One key outside an operation; a stray alu_done may ride along and
    // must be ignored.
    task automatic press(input logic [3:0] c, input bit dn, input logic [W-1:0] res,
                         input string tag, output bit issue);
        m_start = 0;
        modelKey(c, issue);
        applyStimulus(1'b1, c, dn, res);
        checkOutput(tag);
    endtask

    // Plays the ALU after an issue: done arrives in WAIT cycle 'delay'
    // (counting from 0), or never when to_mode is set.
    task automatic runOp(input int delay, input bit to_mode, input logic [W-1:0] res,
                         input bit noisy, input string tag);
        int n;
        m_start = 0;
        applyStimulus(1'b0, 4'd0, 1'b0, '0);
        checkOutput({tag, "_wait"});
        n = to_mode ? TO - 1 : delay;
        for (int i = 0; i < n; i++) begin
            if (noisy)
                applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, '0);
            else
                applyStimulus(1'b0, 4'd0, 1'b0, '0);
        end
        if (n > 0) checkOutput({tag, "_hold"});
        if (to_mode) begin
            applyStimulus(1'b0, 4'd0, 1'b0, '0);
            m_err  = 1;
            m_busy = 0;
        end else begin
            applyStimulus(1'b0, 4'd0, 1'b1, res);
            m_res  = res;
            m_rv   = 1;
            m_busy = 0;
        end
        checkOutput({tag, "_end"});
    endtask

    initial begin
        bit           iss;
        logic [3:0]   c;
        bit           dn;
        int           r;

        rst        = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        alu_done   = 1'b0;
        alu_result = '0;
        modelReset();
        tick();
        tick();
        checkOutput("reset");
        rst = 1'b0;

        // Basic operation: 42 + 7
        press(4'd14, 0, '0, "t1_selA", iss);
        press(4'd4,  0, '0, "t1_d4", iss);
        press(4'd2,  0, '0, "t1_d2", iss);
        press(4'd15, 0, '0, "t1_selB", iss);
        press(4'd7,  0, '0, "t1_d7", iss);
        press(4'd10, 0, '0, "t1_add", iss);
        press(4'd13, 0, '0, "t1_exec", iss);
        cmp("t1", "operand_a_42", operand_a, 32'd42);
        cmp("t1", "operand_b_7",  operand_b, 32'd7);
        cmp("t1", "start_pulse",  W'(alu_start), W'(1));
        runOp(1, 0, 32'd49, 0, "t1_op");
        cmp("t1", "result_49", result_out, 32'd49);

        // Digit limit and re-selection clears the operand
        press(4'd14, 0, '0, "t2_selA", iss);
        press(4'd1,  0, '0, "t2_d1", iss);
        press(4'd2,  0, '0, "t2_d2", iss);
        press(4'd3,  0, '0, "t2_d3", iss);
        cmp("t2", "operand_a_12", operand_a, 32'd12);
        press(4'd14, 0, '0, "t2_selA2", iss);
        cmp("t2", "operand_a_0", operand_a, 32'd0);
        press(4'd5,  0, '0, "t2_d5", iss);
        cmp("t2", "operand_a_5", operand_a, 32'd5);

        // EXECUTE with no operator latched
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        checkOutput("t3_rst");
        press(4'd14, 0, '0, "t3_selA", iss);
        press(4'd5,  0, '0, "t3_d5", iss);
        press(4'd13, 0, '0, "t3_exec", iss);
        cmp("t3", "err_set", W'(err), W'(1));
        press(4'd15, 0, '0, "t3_selB", iss);
        cmp("t3", "err_clr", W'(err), W'(0));

        // Timeout with key noise during WAIT
        press(4'd7,  0, '0, "t4_d7", iss);
        press(4'd11, 0, '0, "t4_sub", iss);
        press(4'd13, 0, '0, "t4_exec", iss);
        runOp(0, 1, '0, 1, "t4_to");

        // Done on the final allowed cycle beats the timeout
        press(4'd12, 0, '0, "t5_mul", iss);
        press(4'd13, 0, '0, "t5_exec", iss);
        runOp(TO - 1, 0, 32'hDEAD_BEEF, 0, "t5_edge");

        // Reset during WAIT, then a late alu_done
        press(4'd13, 0, '0, "t6_exec", iss);
        m_start = 0;
        applyStimulus(1'b0, 4'd0, 1'b0, '0);
        checkOutput("t6_wait");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        applyStimulus(1'b0, 4'd0, 1'b1, 32'd123);
        checkOutput("t6_late_done");

        // Randomized key stream
        for (int it = 0; it < 400; it++) begin
            c  = 4'($urandom_range(0, 15));
            dn = ($urandom_range(0, 3) == 0);
            press(c, dn, W'($urandom), "rnd_key", iss);
            if (iss) begin
                r = $urandom_range(0, 19);
                if (r == 0)
                    runOp(0, 1, '0, 1, "rnd_to");
                else
                    runOp($urandom_range(0, 4), 0, W'($urandom), 1, "rnd_op");
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
